// File: rtl/proc_defs.sv
// Shared processor definitions: FSM state codes, opcodes, ALU operation encoding
// and the control word driven by the multicycle controller.
package proc_defs;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADDR  = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXEC     = 4'd6,
      S_RWB      = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_HALT     = 4'd10
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_AND  = 4'b0010,
      OP_OR   = 4'b0011,
      OP_SLT  = 4'b0100,
      OP_LW   = 4'b1000,
      OP_SW   = 4'b1001,
      OP_BEQ  = 4'b1010,
      OP_JMP  = 4'b1100,
      OP_HALT = 4'b1111
   } opcode_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b100
   } alu_op_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      alu_op_t    alu_op;
      logic [1:0] pc_source;
      logic       halted;
   } ctrl_word_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction/status inputs and control strobes.
interface multicycle_ctrl_if;
   logic [3:0] I_Opcode;
   logic       I_Zero;
   logic       I_MemReady;
   logic       C_PCWrite;
   logic       C_PCWriteCond;
   logic       C_IorD;
   logic       C_MemRead;
   logic       C_MemWrite;
   logic       C_IRWrite;
   logic       C_RegDstWrite;
   logic       C_RegWrite;
   logic       C_MemToReg;
   logic       C_ALUSrcA;
   logic [1:0] C_ALUSrcB;
   logic [2:0] C_ALUOp;
   logic [1:0] C_PCSource;
   logic [3:0] O_State;
   logic       O_Illegal;
   logic       O_Halted;

   modport master (
      input  I_Opcode, I_Zero, I_MemReady,
      output C_PCWrite, C_PCWriteCond, C_IorD, C_MemRead, C_MemWrite, C_IRWrite,
      output C_RegDstWrite, C_RegWrite, C_MemToReg, C_ALUSrcA, C_ALUSrcB,
      output C_ALUOp, C_PCSource, O_State, O_Illegal, O_Halted
   );

   modport slave (
      output I_Opcode, I_Zero, I_MemReady,
      input  C_PCWrite, C_PCWriteCond, C_IorD, C_MemRead, C_MemWrite, C_IRWrite,
      input  C_RegDstWrite, C_RegWrite, C_MemToReg, C_ALUSrcA, C_ALUSrcB,
      input  C_ALUOp, C_PCSource, O_State, O_Illegal, O_Halted
   );
endinterface

// File: rtl/ctrl_decode.sv
// Purely combinational map from the current state to the datapath control word.
module ctrl_decode
   import proc_defs::*;
(
   input  state_t     state_i,
   input  logic [2:0] alu_func_i,
   input  logic       zero_i,
   input  logic       mem_ready_i,
   output ctrl_word_t cw_o
);

   always_comb begin
      cw_o = '0;
      case (state_i)
         S_FETCH: begin
            cw_o.mem_read  = 1'b1;
            cw_o.ir_write  = mem_ready_i;
            cw_o.pc_write  = mem_ready_i;
            cw_o.alu_src_b = 2'b01;
            cw_o.alu_op    = ALU_ADD;
         end
         S_DECODE: begin
            cw_o.alu_src_b = 2'b11;
            cw_o.alu_op    = ALU_ADD;
         end
         S_MEMADDR: begin
            cw_o.alu_src_a = 1'b1;
            cw_o.alu_src_b = 2'b10;
            cw_o.alu_op    = ALU_ADD;
         end
         S_MEMREAD: begin
            cw_o.mem_read = 1'b1;
            cw_o.i_or_d   = 1'b1;
         end
         S_MEMWB: begin
            cw_o.reg_write  = 1'b1;
            cw_o.mem_to_reg = 1'b1;
         end
         S_MEMWRITE: begin
            cw_o.mem_write = 1'b1;
            cw_o.i_or_d    = 1'b1;
         end
         S_EXEC: begin
            cw_o.alu_src_a = 1'b1;
            cw_o.alu_op    = alu_op_t'(alu_func_i);
         end
         S_RWB: begin
            cw_o.reg_write     = 1'b1;
            cw_o.reg_dst_write = 1'b1;
         end
         S_BRANCH: begin
            // The branch target was latched in DECODE; here the ALU compares rs/rt.
            cw_o.alu_src_a     = 1'b1;
            cw_o.alu_op        = ALU_SUB;
            cw_o.pc_source     = 2'b01;
            cw_o.pc_write_cond = zero_i;
         end
         S_JUMP: begin
            cw_o.pc_write  = 1'b1;
            cw_o.pc_source = 2'b10;
         end
         S_HALT:  cw_o.halted = 1'b1;
         default: cw_o = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: state register, next-state logic and
// reset-gated control outputs decoded by ctrl_decode.
module multicycle_ctrl
   import proc_defs::*;
(
   input  logic                clk,
   input  logic                rst,
   multicycle_ctrl_if.master   bus
);

   state_t     state_q, state_d;
   logic       illegal;
   ctrl_word_t cw, cw_g;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      illegal = 1'b0;
      case (state_q)
         S_FETCH:    if (bus.I_MemReady) state_d = S_DECODE;
         S_DECODE: begin
            case (bus.I_Opcode)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: state_d = S_EXEC;
               OP_LW, OP_SW: state_d = S_MEMADDR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_JMP:       state_d = S_JUMP;
               OP_HALT:      state_d = S_HALT;
               default: begin
                  state_d = S_FETCH;
                  illegal = 1'b1;
               end
            endcase
         end
         S_MEMADDR:  state_d = (bus.I_Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (bus.I_MemReady) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (bus.I_MemReady) state_d = S_FETCH;
         S_EXEC:     state_d = S_RWB;
         S_RWB:      state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_JUMP:     state_d = S_FETCH;
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_FETCH;
      endcase
   end

   ctrl_decode u_decode (
      .state_i     (state_q),
      .alu_func_i  (bus.I_Opcode[2:0]),
      .zero_i      (bus.I_Zero),
      .mem_ready_i (bus.I_MemReady),
      .cw_o        (cw)
   );

   // Reset blanks every output combinationally, independent of the clock.
   assign cw_g = rst ? '0 : cw;

   assign bus.C_PCWrite     = cw_g.pc_write;
   assign bus.C_PCWriteCond = cw_g.pc_write_cond;
   assign bus.C_IorD        = cw_g.i_or_d;
   assign bus.C_MemRead     = cw_g.mem_read;
   assign bus.C_MemWrite    = cw_g.mem_write;
   assign bus.C_IRWrite     = cw_g.ir_write;
   assign bus.C_RegDstWrite = cw_g.reg_dst_write;
   assign bus.C_RegWrite    = cw_g.reg_write;
   assign bus.C_MemToReg    = cw_g.mem_to_reg;
   assign bus.C_ALUSrcA     = cw_g.alu_src_a;
   assign bus.C_ALUSrcB     = cw_g.alu_src_b;
   assign bus.C_ALUOp       = cw_g.alu_op;
   assign bus.C_PCSource    = cw_g.pc_source;
   assign bus.O_Halted      = cw_g.halted;
   assign bus.O_State       = rst ? 4'd0 : state_q;
   assign bus.O_Illegal     = illegal & ~rst;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: instruction-level reference model predicts every output each cycle.
module tb_multicycle_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;

   multicycle_ctrl_if bus();

   multicycle_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [22:0] v;
      int          cyc;
   } exp_t;

   exp_t expq[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   // Expected outputs for one cycle of a given instruction phase (state code).
   function automatic logic [22:0] model(input int st, input logic [3:0] op,
                                         input logic rdy, input logic z, input logic r);
      logic pcw, pcwc, iord, mr, mw, irw, rdst, rw, m2r, srca, ill, hlt;
      logic [1:0] srcb, pcsrc;
      logic [2:0] aluop;
      logic [3:0] s;
      {pcw, pcwc, iord, mr, mw, irw, rdst, rw, m2r, srca, ill, hlt} = '0;
      srcb = 2'b00; pcsrc = 2'b00; aluop = 3'b000;
      s = 4'(st);
      if (r) return 23'd0;
      case (st)
         0:  begin mr = 1; irw = rdy; pcw = rdy; srcb = 2'b01; end
         1:  begin
                srcb = 2'b11;
                ill = !((op <= 4'd4) || op == 4'd8 || op == 4'd9 || op == 4'd10 ||
                        op == 4'd12 || op == 4'd15);
             end
         2:  begin srca = 1; srcb = 2'b10; end
         3:  begin mr = 1; iord = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mw = 1; iord = 1; end
         6:  begin srca = 1; aluop = op[2:0]; end
         7:  begin rw = 1; rdst = 1; end
         8:  begin srca = 1; aluop = 3'b001; pcsrc = 2'b01; pcwc = z; end
         9:  begin pcw = 1; pcsrc = 2'b10; end
         10: hlt = 1;
         default: ;
      endcase
      return {pcw, pcwc, iord, mr, mw, irw, rdst, rw, m2r, srca, srcb, aluop, pcsrc, s, ill, hlt};
   endfunction

   function automatic logic [22:0] actual();
      return {bus.C_PCWrite, bus.C_PCWriteCond, bus.C_IorD, bus.C_MemRead, bus.C_MemWrite,
              bus.C_IRWrite, bus.C_RegDstWrite, bus.C_RegWrite, bus.C_MemToReg, bus.C_ALUSrcA,
              bus.C_ALUSrcB, bus.C_ALUOp, bus.C_PCSource, bus.O_State, bus.O_Illegal,
              bus.O_Halted};
   endfunction

   task automatic cycle(input logic r, input int st, input logic rdy,
                        input logic [3:0] op, input logic z);
      exp_t e;
      @(posedge clk);
      #1;
      rst            = r;
      bus.I_MemReady = rdy;
      bus.I_Opcode   = op;
      bus.I_Zero     = z;
      e.v   = model(st, op, rdy, z, r);
      e.cyc = cyc;
      cyc++;
      expq.push_back(e);
   endtask

   task automatic reset_cycles(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 0, rnd(), 4'($urandom_range(0, 15)), rnd());
   endtask

   task automatic instr(input logic [3:0] op, input int fw, input int mw, input logic bz);
      int ms;
      for (int i = 0; i < fw; i++) cycle(1'b0, 0, 1'b0, op, rnd());
      cycle(1'b0, 0, 1'b1, op, rnd());
      cycle(1'b0, 1, rnd(), op, rnd());
      if (op <= 4'd4) begin
         cycle(1'b0, 6, rnd(), op, rnd());
         cycle(1'b0, 7, rnd(), op, rnd());
      end else if (op == 4'd8 || op == 4'd9) begin
         ms = (op == 4'd8) ? 3 : 5;
         cycle(1'b0, 2, rnd(), op, rnd());
         for (int i = 0; i < mw; i++) cycle(1'b0, ms, 1'b0, op, rnd());
         cycle(1'b0, ms, 1'b1, op, rnd());
         if (op == 4'd8) cycle(1'b0, 4, rnd(), op, rnd());
      end else if (op == 4'd10) begin
         cycle(1'b0, 8, rnd(), op, bz);
      end else if (op == 4'd12) begin
         cycle(1'b0, 9, rnd(), op, rnd());
      end else if (op == 4'd15) begin
         for (int i = 0; i < 20; i++) cycle(1'b0, 10, rnd(), op, rnd());
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      logic [22:0] a;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         a = actual();
         n_tests++;
         if (a !== e.v) begin
            n_fail++;
            $display("FAIL cycle%0d outputs: got %h want %h", e.cyc, a, e.v);
         end
      end
   end

   initial begin
      logic [3:0] ops [15];
      ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10, 4'd12,
              4'd5, 4'd6, 4'd7, 4'd11, 4'd13, 4'd14};
      bus.I_Opcode   = 4'd0;
      bus.I_Zero     = 1'b0;
      bus.I_MemReady = 1'b0;

      reset_cycles(2);
      instr(4'd0, 0, 0, 1'b0);           // ADD
      instr(4'd8, 0, 2, 1'b0);           // LW, two wait cycles
      instr(4'd10, 0, 0, 1'b0);          // BEQ not taken
      instr(4'd10, 0, 0, 1'b1);          // BEQ taken
      instr(4'd7, 0, 0, 1'b0);           // illegal opcode

      // SW abandoned by reset during the write wait
      cycle(1'b0, 0, 1'b1, 4'd9, rnd());
      cycle(1'b0, 1, rnd(), 4'd9, rnd());
      cycle(1'b0, 2, rnd(), 4'd9, rnd());
      cycle(1'b0, 5, 1'b0, 4'd9, rnd());
      cycle(1'b0, 5, 1'b0, 4'd9, rnd());
      reset_cycles(2);
      instr(4'd0, 1, 0, 1'b0);

      for (int k = 0; k < 60; k++)
         instr(ops[$urandom_range(0, 14)], $urandom_range(0, 2), $urandom_range(0, 3), rnd());

      instr(4'd15, 0, 0, 1'b0);          // HALT held 20 cycles
      reset_cycles(1);
      instr(4'd3, 0, 0, 1'b0);

      @(posedge clk);
      @(negedge clk);
      #1;
      n_tests++;
      if (expq.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d left want 0", expq.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
